// File: rtl/pixel_capture_pkg.sv
// Shared types and widths for the sensor pixel stream capture block.
package pixel_capture_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        ACTIVE   = 2'd2
    } cap_state_t;

    localparam int unsigned X_W     = 10;
    localparam int unsigned Y_W     = 9;
    localparam int unsigned FRAME_W = 32;

endpackage

// File: rtl/pixel_capture_if.sv
// Sensor-in / pixel-out bundle for pixel_stream_capture.
// oFrameErr exists only when PIXEL_CAPTURE_CHECK_EN is defined.
interface pixel_capture_if #(
    parameter int unsigned DATA_W = 12
);
    logic                                 iFVAL;
    logic                                 iLVAL;
    logic [DATA_W-1:0]                    iDATA;
    logic                                 iSTART;
    logic                                 iEND;
    logic [DATA_W-1:0]                    oDATA;
    logic                                 oDVAL;
    logic [pixel_capture_pkg::X_W-1:0]     oX_Cont;
    logic [pixel_capture_pkg::Y_W-1:0]     oY_Cont;
    logic [pixel_capture_pkg::FRAME_W-1:0] oFrame_Cont;
    logic                                 oBusy;
`ifdef PIXEL_CAPTURE_CHECK_EN
    logic                                 oFrameErr;
`endif

    // Capture block: consumes the sensor stream, produces the pixel stream.
    modport master (
        input  iFVAL, iLVAL, iDATA, iSTART, iEND,
`ifdef PIXEL_CAPTURE_CHECK_EN
        output oFrameErr,
`endif
        output oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oBusy
    );

    // Sensor and downstream consumer side.
    modport slave (
        output iFVAL, iLVAL, iDATA, iSTART, iEND,
`ifdef PIXEL_CAPTURE_CHECK_EN
        input  oFrameErr,
`endif
        input  oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oBusy
    );

endinterface

// File: rtl/capture_coord_counter.sv
// Pixel coordinate counter: X wraps at COLUMN_WIDTH-1 and carries into Y,
// Y wraps at ROW_HEIGHT-1. Clear has priority over increment.
module capture_coord_counter
    import pixel_capture_pkg::*;
#(
    parameter int unsigned COLUMN_WIDTH = 640,
    parameter int unsigned ROW_HEIGHT   = 480
) (
    input  logic           iCLK,
    input  logic           iRST,
    input  logic           clear,
    input  logic           inc,
    output logic [X_W-1:0] x_cont,
    output logic [Y_W-1:0] y_cont
);

    localparam logic [X_W-1:0] X_LAST = X_W'(COLUMN_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROW_HEIGHT - 1);

    // Advance the raster position on each accepted pixel.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            x_cont <= '0;
            y_cont <= '0;
        end else if (clear) begin
            x_cont <= '0;
            y_cont <= '0;
        end else if (inc) begin
            if (x_cont == X_LAST) begin
                x_cont <= '0;
                y_cont <= (y_cont == Y_LAST) ? '0 : y_cont + 1'b1;
            end else begin
                x_cont <= x_cont + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_stream_capture.sv
// Sensor pixel stream capture: frame-aligned start/stop gating, pixel
// coordinates and a captured-frame counter. Two-stage pipeline (input
// register, output register), so iDATA at cycle n appears on oDATA at n+2.
// Optional PIXEL_CAPTURE_CHECK_EN adds a sticky oFrameErr for frames whose
// pixel count does not fill the full raster.
module pixel_stream_capture
    import pixel_capture_pkg::*;
#(
    parameter int unsigned DATA_W       = 12,
    parameter int unsigned COLUMN_WIDTH = 640,
    parameter int unsigned ROW_HEIGHT   = 480
) (
    input  logic            iCLK,
    input  logic            iRST,
    pixel_capture_if.master bus
);

    logic              mFVAL;
    logic              mLVAL;
    logic              pFVAL;
    logic [DATA_W-1:0] mDATA;

    cap_state_t        state;
    cap_state_t        state_next;
    logic              stop_pend;
    logic              stop_pend_next;
    logic              sof_accept;
    logic              sof;
    logic              eof;
    logic              pix_valid;

    logic [X_W-1:0]     x_cnt;
    logic [Y_W-1:0]     y_cnt;
    logic [DATA_W-1:0]  data_q;
    logic               dval_q;
    logic [X_W-1:0]     x_q;
    logic [Y_W-1:0]     y_q;
    logic [FRAME_W-1:0] frame_cnt;
    logic               busy_q;

    // Stage 1: register raw sensor inputs and keep one cycle of FVAL history.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            mFVAL <= 1'b0;
            mLVAL <= 1'b0;
            mDATA <= '0;
            pFVAL <= 1'b0;
        end else begin
            mFVAL <= bus.iFVAL;
            mLVAL <= bus.iLVAL;
            mDATA <= bus.iDATA;
            pFVAL <= mFVAL;
        end
    end

    assign sof       = mFVAL & ~pFVAL;
    assign eof       = ~mFVAL & pFVAL;
    assign pix_valid = (state == ACTIVE) & mFVAL & mLVAL;

    // Next-state logic: gating only changes on frame boundaries.
    always_comb begin
        state_next     = state;
        stop_pend_next = stop_pend;
        sof_accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.iSTART && !bus.iEND) begin
                    state_next = WAIT_SOF;
                end
            end
            WAIT_SOF: begin
                if (bus.iEND) begin
                    state_next = IDLE;
                end else if (sof) begin
                    state_next = ACTIVE;
                    sof_accept = 1'b1;
                end
            end
            ACTIVE: begin
                if (bus.iEND) begin
                    stop_pend_next = 1'b1;
                end
                if (eof) begin
                    state_next     = (stop_pend || bus.iEND) ? IDLE : WAIT_SOF;
                    stop_pend_next = 1'b0;
                end
            end
            default: begin
                state_next     = IDLE;
                stop_pend_next = 1'b0;
            end
        endcase
    end

    // State register, busy flag and frame counter.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state     <= IDLE;
            stop_pend <= 1'b0;
            busy_q    <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_next;
            stop_pend <= stop_pend_next;
            busy_q    <= (state_next != IDLE);
            if (sof_accept) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    capture_coord_counter #(
        .COLUMN_WIDTH (COLUMN_WIDTH),
        .ROW_HEIGHT   (ROW_HEIGHT)
    ) u_coord (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .clear  (sof_accept),
        .inc    (pix_valid),
        .x_cont (x_cnt),
        .y_cont (y_cnt)
    );

    // Stage 2: output register; data and coordinates hold between pixels.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            dval_q <= 1'b0;
            data_q <= '0;
            x_q    <= '0;
            y_q    <= '0;
        end else begin
            dval_q <= pix_valid;
            if (pix_valid) begin
                data_q <= mDATA;
                x_q    <= x_cnt;
                y_q    <= y_cnt;
            end
        end
    end

    assign bus.oDATA       = data_q;
    assign bus.oDVAL       = dval_q;
    assign bus.oX_Cont     = x_q;
    assign bus.oY_Cont     = y_q;
    assign bus.oFrame_Cont = frame_cnt;
    assign bus.oBusy       = busy_q;

`ifdef PIXEL_CAPTURE_CHECK_EN
    logic frame_err;

    // Sticky flag: a captured frame ended without the raster wrapping to (0,0).
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            frame_err <= 1'b0;
        end else if ((state == ACTIVE) && eof && ((x_cnt != '0) || (y_cnt != '0))) begin
            frame_err <= 1'b1;
        end
    end

    assign bus.oFrameErr = frame_err;
`endif

endmodule

// File: tb/tb_pixel_stream_capture.sv
// Randomised bench for pixel_stream_capture on a 4x3 raster, checked
// against a frame-level model of the start/stop gating and a pixel scoreboard.
module tb_pixel_stream_capture;

    localparam int unsigned DATA_W    = 12;
    localparam int          COLS      = 4;
    localparam int          ROWS      = 3;
    localparam int          FRAME_PIX = COLS * ROWS;

    typedef enum {M_IDLE, M_ARMED, M_CAP} mode_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                x;
        int                y;
        int                frame;
        int                cyc;
    } pix_t;

    logic iCLK = 1'b0;
    logic iRST = 1'b0;
    int   cyc  = 0;

    int    err_cnt  = 0;
    int    chk_cnt  = 0;
    mode_t m_mode   = M_IDLE;
    bit    m_stop   = 1'b0;
    int    m_frames = 0;
    bit    m_err    = 1'b0;
    pix_t  exp_q[$];

    pixel_capture_if #(.DATA_W(DATA_W)) pix_if ();

    pixel_stream_capture #(
        .DATA_W       (DATA_W),
        .COLUMN_WIDTH (COLS),
        .ROW_HEIGHT   (ROWS)
    ) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (pix_if)
    );

    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        chk_cnt++;
        if (obs !== expv) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    // Every cycle: oDVAL must match the scoreboard head's due cycle.
    task automatic monitor_loop();
        bit   due;
        pix_t head;
        forever begin
            @(negedge iCLK);
            if (iRST) begin
                due = (exp_q.size() != 0) && (exp_q[0].cyc + 2 == cyc);
                check_val("dval", 32'(pix_if.oDVAL), 32'(due));
                if (due) begin
                    head = exp_q.pop_front();
                    check_val("data",  32'(pix_if.oDATA),       32'(head.data));
                    check_val("x",     32'(pix_if.oX_Cont),     32'(head.x));
                    check_val("y",     32'(pix_if.oY_Cont),     32'(head.y));
                    check_val("frame", 32'(pix_if.oFrame_Cont), 32'(head.frame));
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_dval"},  32'(pix_if.oDVAL),       32'd0);
        check_val({tag, "_data"},  32'(pix_if.oDATA),       32'd0);
        check_val({tag, "_x"},     32'(pix_if.oX_Cont),     32'd0);
        check_val({tag, "_y"},     32'(pix_if.oY_Cont),     32'd0);
        check_val({tag, "_frame"}, 32'(pix_if.oFrame_Cont), 32'd0);
        check_val({tag, "_busy"},  32'(pix_if.oBusy),       32'd0);
`ifdef PIXEL_CAPTURE_CHECK_EN
        check_val({tag, "_ferr"},  32'(pix_if.oFrameErr),   32'd0);
`endif
    endtask

    // Inter-frame gap; op 1 = iSTART, 2 = iEND on gap cycle 3. Status checked at the end.
    task automatic run_gap(input int len, input int op);
        for (int i = 0; i < len; i++) begin
            tick();
            pix_if.iFVAL  = 1'b0;
            pix_if.iLVAL  = 1'b0;
            pix_if.iDATA  = DATA_W'($urandom);
            pix_if.iSTART = (i == 3) && (op == 1);
            pix_if.iEND   = (i == 3) && (op == 2);
            if (i == 3) begin
                if (op == 1 && m_mode == M_IDLE)  m_mode = M_ARMED;
                if (op == 2 && m_mode == M_ARMED) m_mode = M_IDLE;
            end
        end
        @(negedge iCLK);
        check_val("gap_busy",  32'(pix_if.oBusy),       32'(m_mode != M_IDLE));
        check_val("gap_frame", 32'(pix_if.oFrame_Cont), 32'(m_frames));
        check_val("gap_drain", 32'(exp_q.size()),       32'd0);
`ifdef PIXEL_CAPTURE_CHECK_EN
        check_val("gap_ferr",  32'(pix_if.oFrameErr),   32'(m_err));
`endif
    endtask

    // One frame of n_pix pixels; op 1 = iSTART, 2 = iEND, 3 = reset at pixel op_at.
    task automatic run_frame(input int n_pix, input int op, input int op_at, input bit seq_data);
        bit   cap;
        int   line_gap;
        pix_t e;
        tick();
        pix_if.iFVAL  = 1'b1;
        pix_if.iLVAL  = 1'b0;
        pix_if.iDATA  = DATA_W'($urandom);
        pix_if.iSTART = 1'b0;
        pix_if.iEND   = 1'b0;
        // Frame start: an armed capture starts unless iEND lands on the start cycle.
        if (m_mode == M_ARMED) begin
            if (op == 2 && op_at == 0) begin
                m_mode = M_IDLE;
            end else begin
                m_mode = M_CAP;
                m_stop = 1'b0;
                m_frames++;
            end
        end
        cap = (m_mode == M_CAP);
        for (int p = 0; p < n_pix; p++) begin
            tick();
            pix_if.iFVAL  = 1'b1;
            pix_if.iLVAL  = 1'b1;
            pix_if.iDATA  = seq_data ? DATA_W'(32'h100 + p) : DATA_W'($urandom);
            pix_if.iSTART = (op == 1) && (op_at == p);
            pix_if.iEND   = (op == 2) && (op_at == p);
            if (op == 3 && op_at == p) begin
                iRST = 1'b0;
                exp_q.delete();
                m_mode   = M_IDLE;
                m_stop   = 1'b0;
                m_frames = 0;
                m_err    = 1'b0;
                cap      = 1'b0;
                @(negedge iCLK);
                check_reset_outputs("midrst");
                @(posedge iCLK);
                #1;
                iRST = 1'b1;
            end else begin
                if (op == 1 && op_at == p && m_mode == M_IDLE) m_mode = M_ARMED;
                if (op == 2 && op_at == p) begin
                    if (m_mode == M_CAP)        m_stop = 1'b1;
                    else if (m_mode == M_ARMED) m_mode = M_IDLE;
                end
                if (cap) begin
                    e.data  = pix_if.iDATA;
                    e.x     = p % COLS;
                    e.y     = (p / COLS) % ROWS;
                    e.frame = m_frames;
                    e.cyc   = cyc;
                    exp_q.push_back(e);
                end
            end
            if ((p % COLS) == COLS - 1 || p == n_pix - 1) begin
                line_gap = int'($urandom_range(2, 1));
                for (int g = 0; g < line_gap; g++) begin
                    tick();
                    pix_if.iLVAL  = 1'b0;
                    pix_if.iSTART = 1'b0;
                    pix_if.iEND   = 1'b0;
                    pix_if.iDATA  = DATA_W'($urandom);
                end
            end
        end
        // Frame end: a captured frame always completes, then stops or re-arms.
        if (cap) begin
            if (n_pix != FRAME_PIX) m_err = 1'b1;
            m_mode = m_stop ? M_IDLE : M_ARMED;
            m_stop = 1'b0;
        end
    endtask

    initial begin
        int n_pix;
        int op;
        pix_if.iFVAL  = 1'b0;
        pix_if.iLVAL  = 1'b0;
        pix_if.iDATA  = '0;
        pix_if.iSTART = 1'b0;
        pix_if.iEND   = 1'b0;
        fork
            monitor_loop();
        join_none

        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        check_reset_outputs("por");
        tick();
        iRST = 1'b1;
        run_gap(8, 0);

        // Clean sequential frame after a start in the gap.
        run_gap(8, 1);
        run_frame(FRAME_PIX, 0, 0, 1'b1);
        run_gap(8, 0);
        // Reset in the middle of a captured frame, then an ungated frame.
        run_frame(FRAME_PIX, 3, 6, 1'b0);
        run_gap(8, 0);
        run_frame(FRAME_PIX, 0, 0, 1'b0);
        run_gap(8, 0);
        // Start mid-frame: that frame is skipped, the next is frame 1.
        run_frame(FRAME_PIX, 1, 5, 1'b0);
        run_gap(8, 0);
        run_frame(FRAME_PIX, 0, 0, 1'b1);
        run_gap(8, 0);
        // Stop on the 5th pixel of frame 2: frame 2 completes, frame 3 is dropped.
        run_frame(FRAME_PIX, 2, 4, 1'b0);
        run_gap(8, 0);
        run_frame(FRAME_PIX, 0, 0, 1'b0);
        run_gap(8, 0);
        // Stop coinciding with the frame start while waiting.
        run_gap(8, 1);
        run_frame(FRAME_PIX, 2, 0, 1'b0);
        run_gap(8, 0);
        run_frame(FRAME_PIX, 0, 0, 1'b0);
        run_gap(8, 0);
        // Short frame, then a clean one; the frame error flag must stick.
        run_gap(8, 1);
        run_frame(11, 0, 0, 1'b0);
        run_gap(8, 0);
        run_frame(FRAME_PIX, 0, 0, 1'b0);
        run_gap(8, 2);

        // Random frames with random control pulses.
        for (int f = 0; f < 30; f++) begin
            n_pix = ($urandom_range(3, 0) == 0) ? int'($urandom_range(11, 10)) : FRAME_PIX;
            op    = int'($urandom_range(2, 0));
            run_frame(n_pix, op, int'($urandom_range(n_pix - 1, 0)), 1'b0);
            run_gap(int'($urandom_range(10, 7)), int'($urandom_range(2, 0)));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
